// File: rtl/ce_pipe_reg.sv
// ce_pipe_reg: stallable WIDTH x DEPTH register pipeline with valid tracking, flush, occupancy and bypass
module ce_pipe_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  input  logic                       flush,
  input  logic                       bypass,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [OW-1:0]    occ;
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) data[i] <= INIT;
      vld <= '0;
      occ <= '0;
    end else if (flush) begin
      vld <= '0;
      occ <= '0;
    end else if (enable) begin
      data[0] <= din;
      vld[0]  <= din_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data[i] <= data[i-1];
        vld[i]  <= vld[i-1];
      end
      occ <= occ + OW'(din_valid) - OW'(vld[DEPTH-1]);
    end
  end
  always_comb begin
    dout       = bypass ? din : data[DEPTH-1];
    dout_valid = bypass ? din_valid : vld[DEPTH-1];
    occupancy  = occ;
  end
endmodule

// File: tb/tb_ce_pipe_reg.sv
// tb_ce_pipe_reg: scoreboard bench for ce_pipe_reg at DEPTH=4 and DEPTH=1 against a queue model
module tb_ce_pipe_reg;
  logic       clk = 1'b0;
  logic       clr, enable, din_valid, flush, bypass;
  logic [7:0] din;
  logic [7:0] dout4, dout1;
  logic       dv4, dv1;
  logic [2:0] occ4;
  logic       occ1;
  always #5 clk = ~clk;
  ce_pipe_reg #(.WIDTH(8), .DEPTH(4), .INIT(8'hA5)) u4 (
    .clk(clk), .clr(clr), .enable(enable), .din(din), .din_valid(din_valid),
    .flush(flush), .bypass(bypass), .dout(dout4), .dout_valid(dv4), .occupancy(occ4)
  );
  ce_pipe_reg #(.WIDTH(8), .DEPTH(1), .INIT(8'h3C)) u1 (
    .clk(clk), .clr(clr), .enable(enable), .din(din), .din_valid(din_valid),
    .flush(flush), .bypass(bypass), .dout(dout1), .dout_valid(dv1), .occupancy(occ1)
  );
  typedef struct {
    logic [7:0] d4;
    logic       v4;
    int         o4;
    logic [7:0] d1;
    logic       v1;
    int         o1;
    int         n;
  } exp_t;
  exp_t       sb[$];
  exp_t       me;
  logic [7:0] md4[$], md1[$];
  bit         mv4[$], mv1[$];
  int         errors = 0, checks = 0, cyc = 0;
  task automatic model_reset();
    md4.delete(); mv4.delete(); md1.delete(); mv1.delete();
    repeat (4) begin md4.push_back(8'hA5); mv4.push_back(1'b0); end
    md1.push_back(8'h3C); mv1.push_back(1'b0);
  endtask
  function automatic int pop4();
    int n = 0;
    foreach (mv4[i]) n += int'(mv4[i]);
    return n;
  endfunction
  function automatic int pop1();
    int n = 0;
    foreach (mv1[i]) n += int'(mv1[i]);
    return n;
  endfunction
  task automatic check(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", nm, n, act, exp);
    end
  endtask
  task automatic step(input bit c, input bit e, input bit dv, input bit f, input bit b, input logic [7:0] d);
    exp_t ex;
    @(posedge clk);
    #1;
    clr = c; enable = e; din_valid = dv; flush = f; bypass = b; din = d;
    ex.d4 = b ? d : md4[3];
    ex.v4 = b ? dv : mv4[3];
    ex.o4 = pop4();
    ex.d1 = b ? d : md1[0];
    ex.v1 = b ? dv : mv1[0];
    ex.o1 = pop1();
    ex.n  = cyc++;
    sb.push_back(ex);
    if (c) model_reset();
    else if (f) begin
      foreach (mv4[i]) mv4[i] = 1'b0;
      mv1[0] = 1'b0;
    end else if (e) begin
      md4.push_front(d); mv4.push_front(dv); void'(md4.pop_back()); void'(mv4.pop_back());
      md1.push_front(d); mv1.push_front(dv); void'(md1.pop_back()); void'(mv1.pop_back());
    end
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      check("dout4", me.n, 32'(dout4), 32'(me.d4));
      check("dout_valid4", me.n, 32'(dv4), 32'(me.v4));
      check("occupancy4", me.n, 32'(occ4), 32'(me.o4));
      check("dout1", me.n, 32'(dout1), 32'(me.d1));
      check("dout_valid1", me.n, 32'(dv1), 32'(me.v1));
      check("occupancy1", me.n, 32'(occ1), 32'(me.o1));
    end
  end
  initial begin
    clr = 1'b1; enable = 1'b0; din_valid = 1'b0; flush = 1'b0; bypass = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    model_reset();
    step(0, 0, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 5; i++) step(0, 1, 1, 0, 0, 8'(i));
    repeat (5) step(0, 1, 0, 0, 0, 8'h00);
    step(0, 1, 1, 0, 0, 8'h11);
    step(0, 1, 1, 0, 0, 8'h22);
    repeat (3) step(0, 0, 1, 0, 0, 8'h99);
    repeat (5) step(0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 8'h30 + 8'(i));
    step(0, 1, 1, 1, 0, 8'hFF);
    repeat (5) step(0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 8'h10 + 8'(i));
    step(0, 1, 1, 0, 1, 8'h77);
    step(0, 1, 0, 0, 1, 8'h00);
    repeat (6) step(0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) step(0, 1, i[0] == 1'b0, 0, 0, 8'h50 + 8'(i));
    step(1, 1, 1, 1, 0, 8'hEE);
    step(0, 0, 0, 0, 0, 8'h00);
    repeat (400) begin
      step($urandom_range(49) == 0, $urandom_range(3) != 0, $urandom_range(2) != 0,
           $urandom_range(11) == 0, $urandom_range(7) == 0, 8'($urandom));
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
